// File: rtl/strassen_2x2_seq_mac.sv
// strassen_2x2_seq_mac
//
// Signed 2x2 matrix multiply-accumulate built on Strassen's seven products.
// The seven products are computed over ceil(7/NUM_PE) rounds on NUM_PE shared
// multipliers. The block can either overwrite or add to a persistent
// accumulator, so a tile scheduler can sum partial products without any
// external adders. Only one transaction is in flight at a time.
//
// Ports
//   clk, rst    clock and synchronous active-high reset
//   in_valid    A, B and acc are valid
//   in_ready    high only when idle and not in reset
//   acc         1: C = accumulator + A*B, 0: C = A*B
//   A, B        2x2 operands, element (r,c) at [(2r+c)*DATAWIDTH +: DATAWIDTH]
//   out_valid   C holds a result; held until out_ready
//   out_ready   consumer accepts C
//   C           2x2 result, element (r,c) at [(2r+c)*ACCWIDTH +: ACCWIDTH]

module strassen_2x2_seq_mac #(
    parameter int DATAWIDTH = 32,
    parameter int ACCWIDTH  = 2 * DATAWIDTH + 4,
    parameter int NUM_PE    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    acc,
    input  logic [4*DATAWIDTH-1:0]  A,
    input  logic [4*DATAWIDTH-1:0]  B,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*ACCWIDTH-1:0]   C
);

    // Strassen operand width (sum/difference of two elements) and full
    // precision product width.
    localparam int TW = DATAWIDTH + 1;
    localparam int PW = 2 * TW;
    // Number of multiplier rounds needed to cover the seven products.
    localparam int R  = (7 + NUM_PE - 1) / NUM_PE;

    generate
        if (NUM_PE < 1 || NUM_PE > 7) begin : g_bad_num_pe
            $error("strassen_2x2_seq_mac: NUM_PE must be in 1..7");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        MUL  = 3'd2,
        COMB = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Sign-extend one input element to the Strassen operand width.
    function automatic logic signed [TW-1:0] elem_ext(input logic [DATAWIDTH-1:0] v);
        return TW'(signed'(v));
    endfunction

    // Fit a full-precision product into the accumulator width. Sign-extends
    // when the accumulator is wider and wraps when it is narrower; because the
    // result is taken modulo 2^ACCWIDTH anyway, summing the resized products
    // gives the same value as resizing the exact sum.
    function automatic logic signed [ACCWIDTH-1:0] to_acc(input logic signed [PW-1:0] v);
        return ACCWIDTH'(v);
    endfunction

    // Control state
    state_t       state_q, state_d;
    logic [2:0]   round_q, round_d;
    logic         out_valid_q, out_valid_d;

    // Operand capture
    logic                    acc_mode_q, acc_mode_d;
    logic [4*DATAWIDTH-1:0]  a_q, a_d;
    logic [4*DATAWIDTH-1:0]  b_q, b_d;

    // Strassen pre-additions and products
    logic signed [TW-1:0]    t_q [7];
    logic signed [TW-1:0]    t_d [7];
    logic signed [TW-1:0]    s_q [7];
    logic signed [TW-1:0]    s_d [7];
    logic signed [PW-1:0]    m_q [7];
    logic signed [PW-1:0]    m_d [7];

    // Accumulator; it is also the C output register since both always load
    // the same value.
    logic signed [ACCWIDTH-1:0] cacc_q [4];
    logic signed [ACCWIDTH-1:0] cacc_d [4];

    // Shared multipliers
    logic [3:0]              pe_idx  [NUM_PE];
    logic signed [TW-1:0]    pe_a    [NUM_PE];
    logic signed [TW-1:0]    pe_b    [NUM_PE];
    logic signed [PW-1:0]    pe_prod [NUM_PE];

    // Unpacked elements and post-additions
    logic signed [TW-1:0]       ae [4];
    logic signed [TW-1:0]       be [4];
    logic signed [ACCWIDTH-1:0] mr [7];
    logic signed [ACCWIDTH-1:0] pr [4];

    // Each multiplier j handles product index round*NUM_PE + j; indices past
    // the seventh product (last partial round) are fed zeros and discarded.
    always_comb begin
        for (int j = 0; j < NUM_PE; j++) begin
            pe_idx[j]  = 4'(int'(round_q) * NUM_PE + j);
            pe_a[j]    = (pe_idx[j] < 4'd7) ? t_q[pe_idx[j][2:0]] : '0;
            pe_b[j]    = (pe_idx[j] < 4'd7) ? s_q[pe_idx[j][2:0]] : '0;
            pe_prod[j] = pe_a[j] * pe_b[j];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ae[i] = elem_ext(a_q[i*DATAWIDTH +: DATAWIDTH]);
            be[i] = elem_ext(b_q[i*DATAWIDTH +: DATAWIDTH]);
        end
        for (int p = 0; p < 7; p++) begin
            mr[p] = to_acc(m_q[p]);
        end
        pr[0] = mr[0] + mr[3] - mr[4] + mr[6];
        pr[1] = mr[2] + mr[4];
        pr[2] = mr[1] + mr[3];
        pr[3] = mr[0] - mr[1] + mr[2] + mr[5];
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        out_valid_d = out_valid_q;
        acc_mode_d  = acc_mode_q;
        a_d         = a_q;
        b_d         = b_q;
        t_d         = t_q;
        s_d         = s_q;
        m_d         = m_q;
        cacc_d      = cacc_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = A;
                    b_d        = B;
                    acc_mode_d = acc;
                    state_d    = PRE;
                end
            end
            PRE: begin
                t_d[0] = ae[0] + ae[3];
                t_d[1] = ae[2] + ae[3];
                t_d[2] = ae[0];
                t_d[3] = ae[3];
                t_d[4] = ae[0] + ae[1];
                t_d[5] = ae[2] - ae[0];
                t_d[6] = ae[1] - ae[3];
                s_d[0] = be[0] + be[3];
                s_d[1] = be[0];
                s_d[2] = be[1] - be[3];
                s_d[3] = be[2] - be[0];
                s_d[4] = be[3];
                s_d[5] = be[0] + be[1];
                s_d[6] = be[2] + be[3];
                round_d = '0;
                state_d = MUL;
            end
            MUL: begin
                for (int j = 0; j < NUM_PE; j++) begin
                    if (pe_idx[j] < 4'd7) begin
                        m_d[pe_idx[j][2:0]] = pe_prod[j];
                    end
                end
                if (round_q == 3'(R - 1)) begin
                    state_d = COMB;
                end else begin
                    round_d = round_q + 3'd1;
                end
            end
            COMB: begin
                for (int e = 0; e < 4; e++) begin
                    cacc_d[e] = acc_mode_q ? (cacc_q[e] + pr[e]) : pr[e];
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and accumulator: cleared by reset, which also abandons any
    // transaction in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            round_q     <= '0;
            out_valid_q <= 1'b0;
            for (int e = 0; e < 4; e++) begin
                cacc_q[e] <= '0;
            end
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
            cacc_q      <= cacc_d;
        end
    end

    // Operand and intermediate registers: only meaningful after a capture in
    // IDLE, so they carry no reset.
    always_ff @(posedge clk) begin
        acc_mode_q <= acc_mode_d;
        a_q        <= a_d;
        b_q        <= b_d;
        t_q        <= t_d;
        s_q        <= s_d;
        m_q        <= m_d;
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;

    always_comb begin
        C = '0;
        for (int e = 0; e < 4; e++) begin
            C[e*ACCWIDTH +: ACCWIDTH] = cacc_q[e];
        end
    end

endmodule

// File: tb/tb_strassen_2x2_seq_mac.sv
// Testbench for strassen_2x2_seq_mac: four instances (NUM_PE = 1, 3, 4, 7)
// share clock, reset and stimulus. Each accepted transaction pushes the
// expected C and the accept cycle into per-lane queues; a per-lane monitor
// pops and compares whenever that lane raises out_valid.
`timescale 1ns/1ps
module tb_strassen_2x2_seq_mac;

    localparam int DW = 8;
    localparam int AW = 20;
    localparam int NL = 4;
    localparam int CW = 4 * AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic acc_in = 1'b0;
    logic out_ready = 1'b1;
    logic [4*DW-1:0] a_in = '0;
    logic [4*DW-1:0] b_in = '0;

    logic [NL-1:0] in_ready_l;
    logic [NL-1:0] out_valid_l;
    logic [CW-1:0] c_l [NL];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    logic rand_bp = 1'b0;

    logic [CW-1:0] exp_c [NL][$];
    int            exp_t [NL][$];
    logic signed [AW-1:0] model_acc [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    for (genvar l = 0; l < NL; l++) begin : g_lane
        localparam int PE  = (l == 0) ? 1 : (l == 1) ? 3 : (l == 2) ? 4 : 7;
        localparam int LAT = (l == 0) ? 9 : (l == 1) ? 5 : (l == 2) ? 4 : 3;
        logic prev_vld = 1'b0;
        logic prev_rdy = 1'b0;
        logic prev_rst = 1'b1;
        logic [CW-1:0] prev_c = '0;

        strassen_2x2_seq_mac #(
            .DATAWIDTH(DW),
            .ACCWIDTH (AW),
            .NUM_PE   (PE)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready_l[l]),
            .acc      (acc_in),
            .A        (a_in),
            .B        (b_in),
            .out_valid(out_valid_l[l]),
            .out_ready(out_ready),
            .C        (c_l[l])
        );

        always @(negedge clk) begin : mon
            logic [CW-1:0] e;
            int t;
            if (!prev_rst && prev_vld) begin
                if (prev_rdy) begin
                    check($sformatf("lane%0d out_valid after handshake", l), out_valid_l[l], 0);
                end else begin
                    check($sformatf("lane%0d out_valid hold", l), out_valid_l[l], 1);
                    check($sformatf("lane%0d C hold", l), c_l[l], prev_c);
                end
            end else if (out_valid_l[l]) begin
                if (exp_c[l].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL lane%0d unexpected result: got C=%0h, expected no result", l, c_l[l]);
                end else begin
                    e = exp_c[l].pop_front();
                    t = exp_t[l].pop_front();
                    check($sformatf("lane%0d C", l), c_l[l], e);
                    check($sformatf("lane%0d latency", l), cyc - t, LAT);
                end
            end
            prev_vld = out_valid_l[l];
            prev_rdy = out_ready;
            prev_rst = rst;
            prev_c   = c_l[l];
        end
    end

    // Random consumer backpressure, active only while rand_bp is set.
    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [4*DW-1:0] mat(input int e00, input int e01, input int e10, input int e11);
        logic [4*DW-1:0] r;
        r[0*DW +: DW] = DW'(e00);
        r[1*DW +: DW] = DW'(e01);
        r[2*DW +: DW] = DW'(e10);
        r[3*DW +: DW] = DW'(e11);
        return r;
    endfunction

    // Issue one operand pair; expected result is the plain matrix product,
    // optionally added to the model accumulator, wrapped to AW bits.
    task automatic send(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                        input logic acc_i, input logic [NL-1:0] mask);
        logic [CW-1:0] expc;
        logic signed [DW-1:0] x, y;
        int ok, sum;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (in_ready_l == '1) begin
                ok = 1;
                break;
            end
        end
        check("wait in_ready", ok, 1);
        a_in = a; b_in = b; acc_in = acc_i; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in = $urandom; b_in = $urandom; acc_in = 1'($urandom_range(0, 1));
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                sum = 0;
                for (int k = 0; k < 2; k++) begin
                    x = a[(2*r+k)*DW +: DW];
                    y = b[(2*k+c)*DW +: DW];
                    sum += int'(x) * int'(y);
                end
                model_acc[2*r+c] = acc_i ? (model_acc[2*r+c] + AW'(sum)) : AW'(sum);
                expc[(2*r+c)*AW +: AW] = model_acc[2*r+c];
            end
        end
        for (int l = 0; l < NL; l++) begin
            if (mask[l]) begin
                exp_c[l].push_back(expc);
                exp_t[l].push_back(cyc);
            end
        end
    endtask

    task automatic drain();
        int left;
        left = 0;
        for (int i = 0; i < 300; i++) begin
            left = 0;
            for (int l = 0; l < NL; l++) left += exp_c[l].size();
            if (left == 0) break;
            @(posedge clk); #1;
        end
        check("pending results", left, 0);
    endtask

    initial begin
        logic [4*DW-1:0] ba, bb;
        int ok;
        ba = mat(1, 2, 3, 4);
        bb = mat(5, 6, 7, 8);
        for (int e = 0; e < 4; e++) model_acc[e] = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("in_ready during rst", in_ready_l, 0);
        check("out_valid during rst", out_valid_l, 0);
        for (int l = 0; l < NL; l++) check($sformatf("lane%0d C after rst", l), c_l[l], 0);
        rst = 1'b0;
        #1;
        check("in_ready after rst", in_ready_l, 4'hF);

        // Basic, accumulate, overwrite
        send(ba, bb, 1'b0, '1); drain();
        send(ba, bb, 1'b1, '1); drain();
        send(ba, bb, 1'b0, '1); drain();

        // Signed extremes
        send(mat(-128, -128, -128, -128), mat(-128, -128, -128, -128), 1'b0, '1); drain();
        send(mat(127, -128, 0, 1), mat(-128, 127, 1, 0), 1'b0, '1); drain();

        // Random operands and accumulate flags under random backpressure
        rand_bp = 1'b1;
        repeat (25) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), '1);
            drain();
        end
        rand_bp = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Long backpressure with an ignored in_valid pulse
        out_ready = 1'b0;
        send(ba, bb, 1'b0, '1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (out_valid_l[0]) begin
                ok = 1;
                break;
            end
        end
        check("wait out_valid under backpressure", ok, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 4) begin
                a_in = $urandom; b_in = $urandom; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("in_ready while stalled", in_ready_l, 0);
            check("out_valid while stalled", out_valid_l, 4'hF);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("in_ready after release", in_ready_l, 4'hF);
        check("out_valid after release", out_valid_l, 0);
        repeat (20) @(posedge clk);
        #1;
        drain();

        // Reset during MUL round 2 of the NUM_PE=1 lane
        send(ba, bb, 1'b0, '1); drain();
        send(ba, bb, 1'b1, '1); drain();
        // Only the NUM_PE=7 lane finishes before the reset edge.
        send(ba, bb, 1'b1, 4'b1000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("out_valid after mid rst", out_valid_l, 0);
        check("in_ready during mid rst", in_ready_l, 0);
        for (int l = 0; l < NL; l++) check($sformatf("lane%0d C after mid rst", l), c_l[l], 0);
        for (int e = 0; e < 4; e++) model_acc[e] = '0;
        rst = 1'b0;
        send(ba, bb, 1'b1, '1); drain();

        repeat (20) @(posedge clk);
        #1;
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
